demux8_deserializer: RTL and testbench



---
 rtl/demux8_deserializer.sv | 118 +++++++++++
 tb/tb_demux8_deserializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux8_deserializer.sv
// Serial-to-parallel capture: routes each valid serial bit into one of eight
// shadow slots and presents the finished byte with a valid/ack handshake.
module demux8_deserializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       inClk,
  input  logic       inRst_n,
  input  logic       inStart,
  input  logic       inD,
  input  logic       inValid,
  input  logic       inAck,
  output logic [7:0] Y,
  output logic [2:0] outS,
  output logic       outValid,
  output logic       outBusy,
  output logic       outOverrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] y_q, y_d;
  logic       overrun_q, overrun_d;
  logic [2:0] bit_idx;

  // Demux select: slot counter mapped onto the shadow bit position.
  assign bit_idx = MSB_FIRST ? (3'd7 - slot_q) : slot_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the shadow word is reset too, since a
  // partial frame must never leak into a later word.
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= 3'd0;
      shadow_q  <= 8'h00;
      y_q       <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      y_q       <= y_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: every signal gets a hold default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (inStart) begin
          state_d  = ST_COLLECT;
          slot_d   = 3'd0;
          shadow_d = 8'h00;
        end
      end

      ST_COLLECT: begin
        // A restart wins over any bit presented in the same cycle.
        if (inStart) begin
          slot_d   = 3'd0;
          shadow_d = 8'h00;
        end else if (inValid) begin
          shadow_d[bit_idx] = inD;
          if (slot_q == 3'd7) begin
            y_d     = shadow_d;
            slot_d  = 3'd0;
            state_d = ST_HOLD;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end

      ST_HOLD: begin
        if (inAck) begin
          if (inStart) begin
            state_d  = ST_COLLECT;
            slot_d   = 3'd0;
            shadow_d = 8'h00;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (inValid) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        slot_d  = 3'd0;
      end
    endcase
  end

  // Outputs come straight from registers; slot is 0 outside COLLECT.
  always_comb begin
    Y          = y_q;
    outS       = slot_q;
    outValid   = (state_q == ST_HOLD);
    outBusy    = (state_q == ST_COLLECT);
    outOverrun = overrun_q;
  end

endmodule

// File: tb/tb_demux8_deserializer.sv
// Directed bench for demux8_deserializer: LSB-first and MSB-first instances
// share one stimulus; expected words go through a scoreboard queue.
module tb_demux8_deserializer;

  logic       clk, rst_n, start, d, valid, ack;
  logic [7:0] y_l, y_m;
  logic [2:0] s_l, s_m;
  logic       v_l, v_m, b_l, b_m, o_l, o_m;

  int         checks;
  int         failures;
  logic [7:0] exp_l[$];
  logic [7:0] exp_m[$];

  demux8_deserializer #(.MSB_FIRST(1'b0)) u_lsb (
    .inClk(clk), .inRst_n(rst_n), .inStart(start), .inD(d), .inValid(valid),
    .inAck(ack), .Y(y_l), .outS(s_l), .outValid(v_l), .outBusy(b_l),
    .outOverrun(o_l)
  );

  demux8_deserializer #(.MSB_FIRST(1'b1)) u_msb (
    .inClk(clk), .inRst_n(rst_n), .inStart(start), .inD(d), .inValid(valid),
    .inAck(ack), .Y(y_m), .outS(s_m), .outValid(v_m), .outBusy(b_m),
    .outOverrun(o_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic expect_word(input logic [7:0] w);
    exp_l.push_back(w);
    exp_m.push_back(rev8(w));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y_l"}, y_l, 0);
    chk({tag, "_y_m"}, y_m, 0);
    chk({tag, "_s"}, s_l, 0);
    chk({tag, "_valid"}, {v_l, v_m}, 0);
    chk({tag, "_busy"}, {b_l, b_m}, 0);
    chk({tag, "_ovr"}, {o_l, o_m}, 0);
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", {b_l, b_m}, 2'b11);
    chk("start_slot", s_l, 0);
  endtask

  // Sends bits w[0..n-1] in order; optional 1-3 cycle gaps between bits.
  task automatic send_bits(input logic [7:0] w, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      d = w[i];
      valid = 1'b1;
      step();
      valid = 1'b0;
      d = 1'b0;
      if (i < 7) begin
        chk("slot_step", s_l, i + 1);
        chk("slot_step_m", s_m, i + 1);
        chk("busy_mid", b_l, 1);
        chk("valid_mid", v_l, 0);
        if (gaps && i < n - 1) begin
          for (int g = 0; g < 1 + (i % 3); g++) begin
            step();
            chk("slot_gap", s_l, i + 1);
          end
        end
      end
    end
  endtask

  task automatic check_word(input string tag);
    int n;
    logic [7:0] el, em;
    n = 0;
    while (v_l !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, {v_l, v_m}, 2'b11);
    chk({tag, "_sb_nonempty"}, (exp_l.size() > 0), 1);
    if (exp_l.size() > 0) begin
      el = exp_l.pop_front();
      em = exp_m.pop_front();
      chk({tag, "_y_lsb"}, y_l, el);
      chk({tag, "_y_msb"}, y_m, em);
    end
    chk({tag, "_busy_off"}, b_l, 0);
    chk({tag, "_slot_zero"}, s_l, 0);
  endtask

  task automatic ack_word(input logic [7:0] held);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid_low", {v_l, v_m}, 0);
    chk("ack_idle", b_l, 0);
    chk("ack_y_retained", y_l, held);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    d = 1'b0;
    valid = 1'b0;
    ack = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Valid bits in IDLE are ignored.
    valid = 1'b1;
    d = 1'b1;
    step();
    valid = 1'b0;
    chk("idle_ignore_busy", b_l, 0);
    chk("idle_ignore_slot", s_l, 0);

    // Basic frame: 0,1,1,0,1,0,0,1 -> 0x96 LSB-first, 0x69 MSB-first.
    start_frame();
    expect_word(8'h96);
    send_bits(8'h96, 8, 1'b0);
    check_word("basic");
    chk("basic_msb_const", y_m, 8'h69);
    ack_word(8'h96);

    // Same stream with gaps.
    start_frame();
    expect_word(8'h96);
    send_bits(8'h96, 8, 1'b1);
    check_word("gaps");

    // Overrun while holding (ack left low from the previous word).
    ack_word(8'h96);
    start_frame();
    expect_word(8'h96);
    send_bits(8'h96, 8, 1'b0);
    check_word("pre_ovr");
    valid = 1'b1;
    d = 1'b1;
    start = 1'b1;
    repeat (2) step();
    valid = 1'b0;
    start = 1'b0;
    chk("ovr_flag", {o_l, o_m}, 2'b11);
    chk("ovr_valid_held", v_l, 1);
    chk("ovr_y_held", y_l, 8'h96);
    ack_word(8'h96);
    start_frame();
    expect_word(8'hFF);
    send_bits(8'hFF, 8, 1'b0);
    check_word("ones");
    chk("ovr_sticky", o_l, 1);
    ack_word(8'hFF);

    // Abort after 4 bits; restart cycle carries a discarded bit.
    start_frame();
    send_bits(8'h0F, 4, 1'b0);
    start = 1'b1;
    valid = 1'b1;
    d = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b0;
    chk("restart_slot", s_l, 0);
    chk("restart_busy", b_l, 1);
    expect_word(8'h01);
    send_bits(8'h01, 8, 1'b0);
    check_word("restart");
    ack_word(8'h01);

    // Asynchronous reset mid-frame.
    start_frame();
    send_bits(8'h1F, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    rst_n = 1'b1;
    valid = 1'b1;
    d = 1'b1;
    repeat (3) step();
    valid = 1'b0;
    chk("post_rst_valid", v_l, 0);
    chk("post_rst_busy", b_l, 0);

    // Back-to-back frames: ack and start in the same cycle.
    start_frame();
    expect_word(8'h3C);
    send_bits(8'h3C, 8, 1'b0);
    check_word("b2b_first");
    ack = 1'b1;
    start = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    chk("b2b_valid_low", v_l, 0);
    chk("b2b_busy", b_l, 1);
    chk("b2b_slot", s_l, 0);
    expect_word(8'hA5);
    send_bits(8'hA5, 8, 1'b0);
    check_word("b2b_second");
    chk("b2b_y_const", y_l, 8'hA5);
    ack_word(8'hA5);

    chk("sb_drained", exp_l.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
